rtc_display_scanner: RTL and testbench

Downstream consumer of the RTC controller's internal register bank. On request it walks the nine time/date/timer registers through the bank's second read port (`ADDreadreg` / `datamemoria`) and converts each packed-BCD byte into two ASCII digits. The digits go into a 26-character line buffer, which the VGA text renderer reads through a registered character port. The buffer is double-buffered, so the renderer never sees a partially updated line.

---
 rtl/rtc_display_scanner.sv | 146 ++++++++++++++
 tb/tb_rtc_display_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rtc_display_scanner.sv
// rtl/rtc_display_scanner.sv - scans nine BCD RTC registers into a double-buffered 26-char ASCII line
// Shadow/display buffers hold raw BCD bytes; ASCII conversion and separators are applied on the read path.
module rtc_display_scanner #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       actualizar,
  output logic [3:0] ADDreadreg,
  input  logic [7:0] datamemoria,
  input  logic [4:0] char_addr,
  output logic [7:0] char_code,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_COMMIT} state_t;

  localparam int         WAIT_LAST_I = (READ_LAT >= 2) ? READ_LAT - 2 : 0;
  localparam logic [1:0] WAIT_LAST   = WAIT_LAST_I[1:0];

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  wait_q, wait_d;
  logic [7:0]  shadow_q [9];
  logic [7:0]  shadow_d [9];
  logic [7:0]  disp_q [9];
  logic [7:0]  disp_d [9];
  logic [7:0]  char_code_q, char_code_d;

  logic [4:0]  grp, ofs;
  logic [3:0]  sel;
  logic [7:0]  sel_byte;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      wait_q      <= 2'd0;
      char_code_q <= 8'h20;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= 8'h00;
        disp_q[i]   <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      char_code_q <= char_code_d;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= shadow_d[i];
        disp_q[i]   <= disp_d[i];
      end
    end
  end

  // Each register window is READ_LAT+1 cycles; with zero latency ADDR collapses into CAPT.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    ADDreadreg = 4'd0;
    ocupado    = 1'b0;
    listo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (actualizar) begin
          idx_d   = 4'd0;
          state_d = (READ_LAT == 0) ? S_CAPT : S_ADDR;
        end
      end
      S_ADDR: begin
        ADDreadreg = idx_q;
        ocupado    = 1'b1;
        wait_d     = 2'd0;
        state_d    = (READ_LAT >= 2) ? S_WAIT : S_CAPT;
      end
      S_WAIT: begin
        ADDreadreg = idx_q;
        ocupado    = 1'b1;
        if (wait_q == WAIT_LAST) state_d = S_CAPT;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_CAPT: begin
        ADDreadreg       = idx_q;
        ocupado          = 1'b1;
        shadow_d[idx_q]  = datamemoria;
        if (idx_q == 4'd8) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = (READ_LAT == 0) ? S_CAPT : S_ADDR;
        end
      end
      S_COMMIT: begin
        listo   = 1'b1;
        disp_d  = shadow_q;
        idx_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line is nine 3-char groups: tens, units, separator; groups ordered hour..sec, day..year, timer hour..sec.
  always_comb begin
    grp = char_addr / 5'd3;
    ofs = char_addr % 5'd3;
    case (grp)
      5'd0:    sel = 4'd2;
      5'd1:    sel = 4'd1;
      5'd2:    sel = 4'd0;
      5'd3:    sel = 4'd3;
      5'd4:    sel = 4'd4;
      5'd5:    sel = 4'd5;
      5'd6:    sel = 4'd8;
      5'd7:    sel = 4'd7;
      5'd8:    sel = 4'd6;
      default: sel = 4'd0;
    endcase
    sel_byte    = disp_q[sel];
    char_code_d = 8'h20;
    if (char_addr < 5'd26) begin
      if (ofs == 5'd0) begin
        char_code_d = to_ascii(sel_byte[7:4]);
      end else if (ofs == 5'd1) begin
        char_code_d = to_ascii(sel_byte[3:0]);
      end else begin
        case (char_addr)
          5'd2, 5'd5, 5'd20, 5'd23: char_code_d = 8'h3A;
          5'd11, 5'd14:             char_code_d = 8'h2F;
          default:                  char_code_d = 8'h20;
        endcase
      end
    end
  end

  assign char_code = char_code_q;

endmodule

// File: tb/tb_rtc_display_scanner.sv
// tb/tb_rtc_display_scanner.sv - directed self-checking bench for rtc_display_scanner at READ_LAT 0, 1 and 3
module tb_rtc_display_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       actualizar;
  logic [4:0] char_addr;

  logic [3:0] addr0, addr1, addr3;
  logic [7:0] dm0, dm1, dm3;
  logic [7:0] cc0, cc1, cc3;
  logic       oc0, oc1, oc3;
  logic       li0, li1, li3;

  logic [7:0] bank [16];
  logic [3:0] a1_q;
  logic [3:0] a3_q [3];

  int checks   = 0;
  int failures = 0;
  int cyc0, cyc1, cyc3;
  int cnt0, cnt1, cnt3;

  always #5 clk = ~clk;

  rtc_display_scanner #(.READ_LAT(0)) u_l0 (
    .clk(clk), .reset(reset), .actualizar(actualizar), .ADDreadreg(addr0),
    .datamemoria(dm0), .char_addr(char_addr), .char_code(cc0), .ocupado(oc0), .listo(li0));
  rtc_display_scanner #(.READ_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .actualizar(actualizar), .ADDreadreg(addr1),
    .datamemoria(dm1), .char_addr(char_addr), .char_code(cc1), .ocupado(oc1), .listo(li1));
  rtc_display_scanner #(.READ_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .actualizar(actualizar), .ADDreadreg(addr3),
    .datamemoria(dm3), .char_addr(char_addr), .char_code(cc3), .ocupado(oc3), .listo(li3));

  // Register-bank model with per-instance read latency
  always_ff @(posedge clk) begin
    a1_q    <= addr1;
    a3_q[0] <= addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign dm0 = bank[addr0];
  assign dm1 = bank[a1_q];
  assign dm3 = bank[a3_q[2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bank(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
    for (int i = 0; i < 16; i++) bank[i] = 8'h00;
    bank[0] = b0; bank[1] = b1; bank[2] = b2; bank[3] = b3; bank[4] = b4;
    bank[5] = b5; bank[6] = b6; bank[7] = b7; bank[8] = b8;
  endtask

  task automatic check_line(input string tag, input string s);
    logic [7:0] exp;
    for (int a = 0; a < 32; a++) begin
      char_addr = a[4:0];
      step();
      exp = (a < 26) ? s[a] : 8'h20;
      chk($sformatf("%s_l0_pos%0d", tag, a), {24'h0, cc0}, {24'h0, exp});
      chk($sformatf("%s_l1_pos%0d", tag, a), {24'h0, cc1}, {24'h0, exp});
      chk($sformatf("%s_l3_pos%0d", tag, a), {24'h0, cc3}, {24'h0, exp});
    end
  endtask

  // Caller sits #1 after an edge: this cycle is cycle 0 (request sampled at its closing edge).
  task automatic scan(input int repulse_at, input int reset_at, input bit tear);
    cyc0 = -1; cyc1 = -1; cyc3 = -1;
    cnt0 = 0;  cnt1 = 0;  cnt3 = 0;
    actualizar = 1'b1;
    step();
    for (int c = 1; c <= 45; c++) begin
      actualizar = (c == repulse_at);
      reset      = (c == reset_at);
      if (li0) begin cnt0++; if (cyc0 < 0) cyc0 = c; end
      if (li1) begin cnt1++; if (cyc1 < 0) cyc1 = c; end
      if (li3) begin cnt3++; if (cyc3 < 0) cyc3 = c; end
      if (reset_at < 0 && !tear) begin
        if (c <= 18) begin
          chk($sformatf("addr_l1_c%0d", c), {28'h0, addr1}, (c - 1) / 2);
          chk($sformatf("busy_l1_c%0d", c), {31'h0, oc1}, 1);
        end
        if (c == 19) chk("busy_l1_commit", {31'h0, oc1}, 0);
        if (c <= 9)  chk($sformatf("addr_l0_c%0d", c), {28'h0, addr0}, c - 1);
        if (c <= 36) chk($sformatf("addr_l3_c%0d", c), {28'h0, addr3}, (c - 1) / 4);
      end
      if (tear && c <= 25)
        chk($sformatf("tear_l1_c%0d", c), {24'h0, cc1}, (c <= 20) ? 32'h32 : 32'h30);
      step();
    end
    actualizar = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic check_listo(input string tag, input int n_exp);
    chk({tag, "_cnt_l0"}, cnt0, n_exp);
    chk({tag, "_cnt_l1"}, cnt1, n_exp);
    chk({tag, "_cnt_l3"}, cnt3, n_exp);
    if (n_exp > 0) begin
      chk({tag, "_cyc_l0"}, cyc0, 10);
      chk({tag, "_cyc_l1"}, cyc1, 19);
      chk({tag, "_cyc_l3"}, cyc3, 37);
    end
  endtask

  initial begin
    reset      = 1'b1;
    actualizar = 1'b0;
    char_addr  = 5'd0;
    set_bank(8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h16, 8'h05, 8'h10, 8'h01);
    step(); step(); step();
    chk("rst_char_code", {24'h0, cc1}, 32'h20);
    chk("rst_busy", {29'h0, oc0, oc1, oc3}, 0);
    chk("rst_listo", {29'h0, li0, li1, li3}, 0);
    chk("rst_addr", {20'h0, addr0, addr1, addr3}, 0);
    reset = 1'b0;
    step();
    check_line("rst_line", "00:00:00 00/00/00 00:00:00");

    scan(-1, -1, 1'b0);
    check_listo("full", 1);
    chk("full_idle_busy", {29'h0, oc0, oc1, oc3}, 0);
    check_line("full_line", "23:59:45 31/12/16 01:10:05");

    bank[1] = 8'hA7;
    scan(-1, -1, 1'b0);
    check_listo("bcd", 1);
    check_line("bcd_line", "23:?7:45 31/12/16 01:10:05");

    bank[1]   = 8'h59;
    bank[2]   = 8'h00;
    char_addr = 5'd0;
    step();
    scan(-1, -1, 1'b1);
    check_listo("tear", 1);
    check_line("tear_line", "00:59:45 31/12/16 01:10:05");

    bank[2] = 8'h23;
    scan(5, -1, 1'b0);
    check_listo("repulse", 1);
    check_line("repulse_line", "23:59:45 31/12/16 01:10:05");

    scan(-1, 7, 1'b0);
    check_listo("abort", 0);
    chk("abort_busy", {29'h0, oc0, oc1, oc3}, 0);
    check_line("abort_line", "00:00:00 00/00/00 00:00:00");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
